// File: rtl/poly_operand_driver.sv
// poly_operand_driver: drives the evaluator's Go/DataIn load handshake for
// operands A, B, C, X, then captures the armed ResultValid into a held result.
// Ports: clk, reset (sync, active-high), start, op_a/op_b/op_c/op_x [7:0],
//   result_in [7:0], valid_in -> go, data_out [7:0], result [7:0], busy,
//   done, error, current_state [3:0] (IDLE=0 GO_HIGH=1 GO_LOW=2 WAIT=3 DONE=4).
// Optional feature: define SEQ_TIMEOUT_EN to abort WAIT after TIMEOUT_CYCLES.
module poly_operand_driver #(
  parameter int GO_HIGH_CYCLES = 2,
  parameter int GO_LOW_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] op_a,
  input  logic [7:0] op_b,
  input  logic [7:0] op_c,
  input  logic [7:0] op_x,
  input  logic [7:0] result_in,
  input  logic       valid_in,
  output logic       go,
  output logic [7:0] data_out,
  output logic [7:0] result,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [3:0] current_state
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_GO_HIGH = 4'd1,
    S_GO_LOW  = 4'd2,
    S_WAIT    = 4'd3,
    S_DONE    = 4'd4
  } state_t;

  localparam int PMAX =
    (GO_HIGH_CYCLES > GO_LOW_CYCLES) ? GO_HIGH_CYCLES : GO_LOW_CYCLES;
  localparam int PW = (PMAX > 1) ? $clog2(PMAX) : 1;
  localparam logic [PW-1:0] HI_LAST = PW'(GO_HIGH_CYCLES - 1);
  localparam logic [PW-1:0] LO_LAST = PW'(GO_LOW_CYCLES - 1);

  if (GO_HIGH_CYCLES < 1 || GO_LOW_CYCLES < 1 ||
      TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("poly_operand_driver: cycle parameters must be >= 1");
  end

  state_t          state, state_n;
  logic [7:0]      opa_q, opb_q, opc_q, opx_q;
  logic [1:0]      idx, idx_n;
  logic [PW-1:0]   phase, phase_n;
  logic            arm, arm_n;
  logic [7:0]      result_q;
  logic            load;
  logic            capture;
  logic            tmo_hit;

`ifdef SEQ_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo_cnt;
  logic          err_q;

  // Counter holds the number of WAIT cycles already spent; it is zero in
  // every other state so it is clear on each WAIT entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= tmo_hit;
      if (state == S_WAIT && state_n == S_WAIT) begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end else begin
        tmo_cnt <= '0;
      end
    end
  end

  assign error = err_q;
`else
  assign error = 1'b0;
`endif

  always_comb begin
    state_n = state;
    idx_n   = idx;
    phase_n = phase;
    arm_n   = arm;
    load    = 1'b0;
    capture = 1'b0;
    tmo_hit = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          load    = 1'b1;
          idx_n   = 2'd0;
          phase_n = '0;
          state_n = S_GO_HIGH;
        end
      end
      S_GO_HIGH: begin
        if (phase == HI_LAST) begin
          phase_n = '0;
          state_n = S_GO_LOW;
        end else begin
          phase_n = phase + PW'(1);
        end
      end
      S_GO_LOW: begin
        if (phase == LO_LAST) begin
          phase_n = '0;
          if (idx == 2'd3) begin
            arm_n   = 1'b0;
            state_n = S_WAIT;
          end else begin
            idx_n   = idx + 2'd1;
            state_n = S_GO_HIGH;
          end
        end else begin
          phase_n = phase + PW'(1);
        end
      end
      S_WAIT: begin
        // A valid seen before any low sample is the evaluator's stale
        // result from the previous run, so it must not be captured.
        if (valid_in && arm) begin
          capture = 1'b1;
          state_n = S_DONE;
        end else begin
          if (!valid_in) begin
            arm_n = 1'b1;
          end
`ifdef SEQ_TIMEOUT_EN
          if (tmo_cnt == TMO_LAST) begin
            tmo_hit = 1'b1;
            state_n = S_IDLE;
          end
`endif
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      idx      <= 2'd0;
      phase    <= '0;
      arm      <= 1'b0;
      opa_q    <= 8'd0;
      opb_q    <= 8'd0;
      opc_q    <= 8'd0;
      opx_q    <= 8'd0;
      result_q <= 8'd0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      phase <= phase_n;
      arm   <= arm_n;
      if (load) begin
        opa_q <= op_a;
        opb_q <= op_b;
        opc_q <= op_c;
        opx_q <= op_x;
      end
      if (capture) begin
        result_q <= result_in;
      end
    end
  end

  // Outputs decode registered state only, so Go and DataOut can move
  // only at state or index transitions.
  logic [7:0] op_sel;

  always_comb begin
    op_sel = 8'd0;
    unique case (idx)
      2'd0: op_sel = opa_q;
      2'd1: op_sel = opb_q;
      2'd2: op_sel = opc_q;
      2'd3: op_sel = opx_q;
      default: op_sel = 8'd0;
    endcase
  end

  assign go            = (state == S_GO_HIGH);
  assign data_out      = (state == S_GO_HIGH || state == S_GO_LOW) ?
                         op_sel : 8'd0;
  assign result        = result_q;
  assign busy          = (state != S_IDLE);
  assign done          = (state == S_DONE);
  assign current_state = state;

endmodule

// File: tb/tb_poly_operand_driver.sv
// Bench for poly_operand_driver: random and directed load transactions with
// a behavioural evaluator; a negedge monitor checks against queued expectations.
module tb_poly_operand_driver;

  localparam int GH = 2;
  localparam int GL = 2;
  localparam int TMO = 32;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] op_a = 8'd0, op_b = 8'd0, op_c = 8'd0, op_x = 8'd0;
  logic [7:0] result_in = 8'd0;
  logic       valid_in = 1'b0;
  logic       go, busy, done, error;
  logic [7:0] data_out, result;
  logic [3:0] current_state;

  poly_operand_driver #(
    .GO_HIGH_CYCLES(GH),
    .GO_LOW_CYCLES(GL),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .op_a(op_a),
    .op_b(op_b),
    .op_c(op_c),
    .op_x(op_x),
    .result_in(result_in),
    .valid_in(valid_in),
    .go(go),
    .data_out(data_out),
    .result(result),
    .busy(busy),
    .done(done),
    .error(error),
    .current_state(current_state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][7:0] op;
    logic [7:0]      res;
    logic            mute;
    logic            b2b;
  } txn_t;

  txn_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_done = 0;
  int   exp_done = 0;
  bit   held_start = 0;

  function automatic logic [7:0] eval(input int a, b, c, x);
    int v;
    v = a * x * x + b * x + c;
    return 8'(v);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor plus behavioural evaluator, all on the falling edge.
  initial begin : monitor
    int   cyc, last_done, sel, hi_cnt, lo_cnt, ev, w0;
    bit   prev_go, have;
    txn_t cur;
    logic [7:0] held;
    cyc = 0; last_done = -100; sel = 0; hi_cnt = 0; lo_cnt = 0;
    ev = -1; w0 = 1; prev_go = 0; have = 0; held = 8'd0; cur = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        have = 0; sel = 0; ev = -1; prev_go = 0; held = 8'd0;
        valid_in = 1'b0; result_in = 8'd0;
        continue;
      end
      if (ev >= 0) begin
        ev++;
        if (ev == 3) valid_in = 1'b0;
        if (ev == 3 + w0) begin
          if (!cur.mute) begin
            valid_in = 1'b1;
            result_in = cur.res;
          end
          ev = -1;
          sel = 0;
        end
      end
      if (go && !prev_go) begin
        if (sel == 0) begin
          if (q.size() == 0) begin
            check("go_without_txn", 1, 0);
            have = 0;
          end else begin
            cur = q.pop_front();
            have = 1;
            if (cur.b2b) check("b2b_go_gap", cyc - last_done, 2);
          end
        end else begin
          check("go_low_width", lo_cnt, GL);
        end
        sel++;
        hi_cnt = 0;
      end
      if (!go && prev_go) begin
        check("go_high_width", hi_cnt, GH);
        lo_cnt = 0;
        if (sel == 4) begin
          ev = 0;
          w0 = $urandom_range(1, 3);
          if (cur.mute) begin
            valid_in = 1'b1;
            result_in = ~cur.res;
          end else if ($urandom % 2 == 1) begin
            result_in = ~cur.res;
          end else begin
            valid_in = 1'b0;
          end
        end
      end
      if (go) hi_cnt++;
      if (!go && sel >= 1 && sel <= 3) lo_cnt++;
      if (current_state == 4'd1 || current_state == 4'd2) begin
        if (have && sel >= 1 && sel <= 4) check("data_out_op", data_out, cur.op[sel-1]);
        else check("go_phase_no_txn", 1, 0);
      end else begin
        check("data_out_zero", data_out, 0);
      end
      if (done) begin
        n_done++;
        last_done = cyc;
        if (!have || cur.mute) check("unexpected_done", 1, 0);
        else begin
          check("result", result, cur.res);
          held = cur.res;
        end
        have = 0;
      end else begin
        check("result_hold", result, held);
      end
`ifndef SEQ_TIMEOUT_EN
      check("error_zero", error, 0);
`endif
      prev_go = go;
    end
  end

  task automatic launch(input logic [7:0] a, b, c, x,
                        input bit hold, scr, mute, abort);
    txn_t t;
    int   n;
    n = 0;
    @(negedge clk);
    while (busy) begin
      if (n >= 300) begin
        check("idle_timeout", 0, 1);
        return;
      end
      @(negedge clk);
      n++;
    end
    op_a = a; op_b = b; op_c = c; op_x = x;
    start = 1'b1;
    t.op = {x, c, b, a};
    t.res = eval(a, b, c, x);
    t.mute = mute;
    t.b2b = held_start;
    q.push_back(t);
    if (!mute && !abort) exp_done++;
    @(negedge clk);
    check("go_after_start", go, 1);
    check("dout_a_after_start", data_out, a);
    start = hold;
    held_start = hold;
    if (scr) begin
      op_a = 8'hFF; op_b = 8'hFF; op_c = 8'hFF; op_x = 8'hFF;
    end else begin
      op_a = 8'($urandom); op_b = 8'($urandom);
      op_c = 8'($urandom); op_x = 8'($urandom);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("final_idle_timeout", 0, 1);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    logic [7:0] last_res;
    repeat (2) @(negedge clk);
    check("rst_go", go, 0);
    check("rst_data_out", data_out, 0);
    check("rst_result", result, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_state", current_state, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    launch(8'd1, 8'd2, 8'd3, 8'd4, 0, 0, 0, 0);
    launch(8'd3, 8'd5, 8'd7, 8'd10, 0, 0, 0, 0);
    launch(8'd1, 8'd2, 8'd3, 8'd4, 0, 1, 0, 0);
    launch(8'd9, 8'd8, 8'd7, 8'd6, 1, 0, 0, 0);
    launch(8'd250, 8'd17, 8'd33, 8'd129, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      launch(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
             (i < 7) ? bit'($urandom % 2) : 1'b0, bit'($urandom % 2), 0, 0);
    end

    // Reset during GO_HIGH of operand C.
    launch(8'd11, 8'd22, 8'd33, 8'd44, 0, 0, 0, 1);
    repeat (8) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("pre_rst_go_c", go, 1);
    check("pre_rst_dout_c", data_out, 33);
    @(negedge clk);
    check("midrst_go", go, 0);
    check("midrst_busy", busy, 0);
    check("midrst_state", current_state, 0);
    check("midrst_result", result, 0);
    check("midrst_data_out", data_out, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    launch(8'd2, 8'd0, 8'd1, 8'd3, 0, 0, 0, 0);
    wait_idle();
    last_res = eval(2, 0, 1, 3);

    // Stale valid at WAIT entry, then no result at all.
    launch(8'd5, 8'd6, 8'd7, 8'd8, 0, 0, 1, 0);
    n = 0;
    while (current_state != 4'd3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("mute_reached_wait", current_state, 3);
    repeat (TMO - 1) @(negedge clk);
    check("mute_busy_last_wait", busy, 1);
    @(negedge clk);
`ifdef SEQ_TIMEOUT_EN
    check("tmo_error", error, 1);
    check("tmo_busy", busy, 0);
    check("tmo_state", current_state, 0);
    check("tmo_result", result, last_res);
    @(negedge clk);
    check("tmo_error_pulse", error, 0);
`else
    check("notmo_busy", busy, 1);
    check("notmo_state", current_state, 3);
    repeat (20) @(negedge clk);
    check("notmo_busy_late", busy, 1);
    check("notmo_result", result, last_res);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
`endif

    launch(8'd4, 8'd3, 8'd2, 8'd1, 0, 0, 0, 0);
    wait_idle();
    repeat (3) @(negedge clk);
    check("done_count", n_done, exp_done);
    check("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/poly_operand_driver.md
# poly_operand_driver

Initiator-side sequencer for the polynomial evaluator's Go/DataIn load protocol. It latches four operands (A, B, C, X) on a start request, then drives the evaluator's DataIn bus and Go line through four press/release handshakes in the order A, B, C, X. It waits for the evaluator's ResultValid and captures DataResult into a held result register. It sits between a host or test controller and the evaluator, replacing manual switch and key stimulus.

## Interface
- GO_HIGH_CYCLES, 2, cycles Go is held high per operand; must be ≥1.
- GO_LOW_CYCLES, 2, cycles Go is held low after each release; must be ≥1.
- TIMEOUT_CYCLES, 32, maximum cycles spent in WAIT before abort. Used only with SEQ_TIMEOUT_EN.
- Clock  in  1  single clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  request; sampled only in IDLE.
- OpA, OpB, OpC, OpX  in  8 each  operands; latched on the accepted Start.
- ResultIn  in  8  evaluator DataResult.
- ValidIn  in  1  evaluator ResultValid.
- Go  out  1  evaluator Go.
- DataOut  out  8  evaluator DataIn.
- Result  out  8  last captured result.
- Busy  out  1  high in every state except IDLE.
- Done  out  1  one-cycle pulse when Result is updated.
- Error  out  1  one-cycle timeout pulse; constant 0 without SEQ_TIMEOUT_EN.
- current_state  out  4  state encoding: IDLE=0, GO_HIGH=1, GO_LOW=2, WAIT=3, DONE=4.

## Operation
- Registers:
  - four 8-bit operand latches;
  - a 2-bit operand index (0=A, 1=B, 2=C, 3=X);
  - a phase counter sized for max(GO_HIGH_CYCLES, GO_LOW_CYCLES);
  - an arm flag;
  - an 8-bit Result register;
  - a timeout counter (SEQ_TIMEOUT_EN only).
- IDLE: Start=1 latches OpA..OpX, clears the index and phase counter, and goes to GO_HIGH. Start=0 stays in IDLE.
- GO_HIGH: Go=1. After GO_HIGH_CYCLES cycles, go to GO_LOW.
- GO_LOW: Go=0. After GO_LOW_CYCLES cycles:
  - index<3: increment the index, go to GO_HIGH;
  - index=3: clear the arm flag, go to WAIT.
- DataOut is the latched operand selected by the index. It is stable for every cycle of GO_HIGH and GO_LOW. It is 0 in IDLE, WAIT and DONE.
- WAIT:
  - ValidIn sampled 0 sets the arm flag.
  - ValidIn sampled 1 while armed captures ResultIn into Result and goes to DONE.
  - ValidIn=1 while not armed is ignored. This rejects the evaluator's stale valid from a previous result.
- DONE: Done=1 for one cycle, then IDLE.
- Start outside IDLE is ignored. Start held high re-launches immediately from IDLE, giving back-to-back transactions.
- Arithmetic is not performed here. Result is ResultIn exactly, 8-bit, with modulo-256 wrap occurring inside the evaluator.

## Timing
- Reset values: state IDLE, Go=0, DataOut=0, Result=0, Busy=0, Done=0, Error=0, current_state=0, index=0, arm=0.
- Reset mid-transaction: at the next edge, return to the reset values, including clearing Result. No partial handshake is completed.
- Start sampled at edge t: Go=1 and DataOut=A during cycle t+1.
- Each operand occupies GO_HIGH_CYCLES+GO_LOW_CYCLES cycles. With the defaults, X is released at cycle t+15 and WAIT is entered at t+17.
- Done is asserted in the cycle after the armed ValidIn=1 sample. Result updates on that same edge and holds until the next capture or reset.
- Busy falls in the cycle after DONE. The earliest next Go=1 is two cycles after Done.
- Go and DataOut change only at state or index transitions, never mid-phase.

## Configuration
- SEQ_TIMEOUT_EN defined:
  - the timeout counter runs in WAIT and clears on WAIT entry;
  - after TIMEOUT_CYCLES cycles in WAIT without capture, go to IDLE;
  - Error pulses for one cycle; Result is unchanged; Done is not asserted.
- SEQ_TIMEOUT_EN undefined:
  - no counter is built and WAIT persists until capture or Reset;
  - Error is tied to 0.

## Test plan
- A=1, B=2, C=3, X=4 against the behavioural evaluator -> exactly four Go pulses, each 2 cycles high, with DataOut=1, 2, 3, 4 during those pulses; Result=27 (0x1B); Done pulses once.
- A=3, B=5, C=7, X=10 -> Result=101 (8-bit wrap of 357).
- OpA..OpX changed to 0xFF the cycle after Start -> DataOut still presents the latched values; Result is unchanged from the original-operand case.
- Start held high across two transactions with different operands -> two Done pulses; second Go rise exactly two cycles after the first Done; both Results are correct.
- Reset asserted during GO_HIGH of operand C -> the next cycle shows Go=0, Busy=0, current_state=0, Result=0.
- ValidIn held 1 at WAIT entry, then held 0 -> no capture. With SEQ_TIMEOUT_EN, Error pulses after 32 WAIT cycles and Busy falls; without it, Busy stays 1 indefinitely.
